// File: rtl/hdc_pkg.sv
// Shared constants and types for the HDC ham/spam trainer and classifier.
// Both blocks must agree on the hypervector geometry and the class encoding.
package hdc_pkg;

  localparam int DIM       = 10000;
  localparam int W         = 32;
  localparam int CNT_W     = 16;
  localparam int NUM_WORDS = (DIM + W - 1) / W;

  localparam logic CLASS_HAM  = 1'b0;
  localparam logic CLASS_SPAM = 1'b1;

  // Bipolar mapping of a hypervector bit: 1 -> +1, 0 -> -1
  localparam int BIPOLAR_POS = 1;
  localparam int BIPOLAR_NEG = -1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_READ
  } state_t;

endpackage

// File: rtl/hdc_sat_acc.sv
// One saturating bipolar counter lane: adds +1 or -1 when enabled,
// clamping symmetrically at +/-(2^(CNT_W-1)-1).
module hdc_sat_acc #(
  parameter int CNT_W = hdc_pkg::CNT_W
) (
  input  logic                    en,
  input  logic                    up,
  input  logic signed [CNT_W-1:0] cnt_in,
  output logic signed [CNT_W-1:0] cnt_out
);
  import hdc_pkg::*;

  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = -CNT_MAX;

  always_comb begin
    cnt_out = cnt_in;
    if (en) begin
      if (up && (cnt_in != CNT_MAX)) begin
        cnt_out = cnt_in + CNT_W'(BIPOLAR_POS);
      end else if (!up && (cnt_in != CNT_MIN)) begin
        cnt_out = cnt_in + CNT_W'(BIPOLAR_NEG);
      end
    end
  end

endmodule

// File: rtl/hdc_class_trainer.sv
// HDC trainer: bundles labelled message hypervectors into per-class saturating
// counters and streams the binarized ham then spam class vectors on request.
module hdc_class_trainer #(
  parameter int DIM   = hdc_pkg::DIM,
  parameter int W     = hdc_pkg::W,
  parameter int CNT_W = hdc_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_label,
  input  logic          in_last,
  input  logic          rd_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_class,
  output logic          out_last,
  output logic          busy,
  output logic          err_frame,
  output logic [15:0]   cnt_ham,
  output logic [15:0]   cnt_spam
);
  import hdc_pkg::*;

  localparam int NUM_WORDS = (DIM + W - 1) / W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               label_q, label_d;
  logic               out_valid_d, out_class_d, out_last_d, err_d;
  logic [W-1:0]       out_data_d;
  logic [15:0]        ham_d, spam_d;

  logic [W*CNT_W-1:0] acc_mem [2][NUM_WORDS];
  logic [W*CNT_W-1:0] rd_word, upd_word;
  logic [W-1:0]       bit_live, bin_word;
  logic               rd_cls, acc_cls, nxt_cls;
  logic [IDX_W-1:0]   rd_idx, nxt_idx;
  logic               last_idx, clr_we, acc_we;

  assign busy     = (state_q != ST_IDLE);
  assign last_idx = (word_idx_q == IDX_LAST);
  assign acc_cls  = (state_q == ST_IDLE) ? in_label : label_q;
  assign nxt_cls  = last_idx ? CLASS_SPAM : out_class;
  assign nxt_idx  = last_idx ? '0 : word_idx_q + IDX_W'(1);

  // During readout the array is addressed one word ahead so the registered
  // output can advance on the same cycle as the handshake.
  always_comb begin
    rd_cls = acc_cls;
    rd_idx = word_idx_q;
    if ((state_q == ST_IDLE) && rd_start) begin
      rd_cls = CLASS_HAM;
      rd_idx = '0;
    end else if (state_q == ST_READ) begin
      rd_cls = nxt_cls;
      rd_idx = nxt_idx;
    end
  end

  assign rd_word = acc_mem[rd_cls][rd_idx];

  for (genvar d = 0; d < W; d++) begin : g_lane
    assign bit_live[d] = ((int'(rd_idx) * W + d) < DIM);
    assign bin_word[d] = bit_live[d] && ($signed(rd_word[d*CNT_W +: CNT_W]) > 0);

    hdc_sat_acc #(.CNT_W(CNT_W)) u_acc (
      .en      (bit_live[d]),
      .up      (in_data[d]),
      .cnt_in  (rd_word[d*CNT_W +: CNT_W]),
      .cnt_out (upd_word[d*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      acc_mem[CLASS_HAM][word_idx_q]  <= '0;
      acc_mem[CLASS_SPAM][word_idx_q] <= '0;
    end else if (acc_we) begin
      acc_mem[acc_cls][word_idx_q] <= upd_word;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    label_d     = label_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_class_d = out_class;
    out_last_d  = out_last;
    err_d       = err_frame;
    ham_d       = cnt_ham;
    spam_d      = cnt_spam;
    in_ready    = 1'b0;
    clr_we      = 1'b0;
    acc_we      = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (last_idx) begin
          state_d    = ST_IDLE;
          word_idx_d = '0;
        end else begin
          word_idx_d = word_idx_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        in_ready = !clear && !rd_start;
        if (rd_start && !clear) begin
          state_d     = ST_READ;
          word_idx_d  = '0;
          out_valid_d = 1'b1;
          out_data_d  = bin_word;
          out_class_d = CLASS_HAM;
          out_last_d  = (NUM_WORDS == 1);
        end
      end
      ST_ACCUM: begin
        in_ready = !clear;
      end
      ST_READ: begin
        if (out_valid && out_ready) begin
          if (out_last && (out_class == CLASS_SPAM)) begin
            state_d     = ST_IDLE;
            word_idx_d  = '0;
            out_valid_d = 1'b0;
          end else begin
            word_idx_d  = nxt_idx;
            out_data_d  = bin_word;
            out_class_d = nxt_cls;
            out_last_d  = (nxt_idx == IDX_LAST);
          end
        end
      end
      default: ;
    endcase

    if (in_valid && in_ready) begin
      acc_we  = 1'b1;
      label_d = acc_cls;
      if (in_last) begin
        if (last_idx) begin
          if (acc_cls == CLASS_SPAM) spam_d = (cnt_spam == '1) ? cnt_spam : cnt_spam + 16'd1;
          else                       ham_d  = (cnt_ham == '1) ? cnt_ham : cnt_ham + 16'd1;
        end else begin
          err_d = 1'b1;
        end
        word_idx_d = '0;
        state_d    = ST_IDLE;
      end else begin
        if (last_idx) begin
          err_d      = 1'b1;
          word_idx_d = '0;
        end else begin
          word_idx_d = word_idx_q + IDX_W'(1);
        end
        state_d = ST_ACCUM;
      end
    end

    if (clear) begin
      state_d     = ST_CLEAR;
      word_idx_d  = '0;
      out_valid_d = 1'b0;
      ham_d       = '0;
      spam_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      word_idx_q <= '0;
      label_q    <= CLASS_HAM;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_class  <= CLASS_HAM;
      out_last   <= 1'b0;
      err_frame  <= 1'b0;
      cnt_ham    <= '0;
      cnt_spam   <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      label_q    <= label_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_class  <= out_class_d;
      out_last   <= out_last_d;
      err_frame  <= err_d;
      cnt_ham    <= ham_d;
      cnt_spam   <= spam_d;
    end
  end

endmodule

// File: doc/hdc_class_trainer.md
Name: hdc_class_trainer

Overview:
- Training counterpart of the HDC ham/spam classifier: it writes the class reference hypervectors that the classifier later reads and compares by Hamming distance.
- Accepts encoded binary message hypervectors, streamed W bits per word, each tagged with a class label.
- Bundles each dimension into a per-class saturating signed counter, then streams the binarized class vectors (ham first, then spam) to the reference-memory loader.

Parameters:
- DIM, 10000, hypervector dimension in bits.
- W, 32, word width of the input and output streams.
- CNT_W, 16, signed accumulator width per dimension per class.
- NUM_WORDS, ceil(DIM/W) = 313, words per hypervector (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  one-cycle pulse: zero all accumulators and sample counts.
- in_valid  in  1  input word valid.
- in_ready  out  1  trainer can accept an input word.
- in_data  in  W  hypervector bits; bit=1 means +1, bit=0 means -1.
- in_label  in  1  0 = ham, 1 = spam; sampled on word 0 of each sample.
- in_last  in  1  marks the final word of a sample.
- rd_start  in  1  one-cycle pulse: start streaming the class vectors.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  W  binarized class-vector word.
- out_class  out  1  class of the current output word.
- out_last  out  1  final word of the current class.
- busy  out  1  high in the CLEAR, ACCUM and READ states.
- err_frame  out  1  sticky: in_last did not line up with word NUM_WORDS-1.
- cnt_ham  out  16  number of ham samples accepted (saturating).
- cnt_spam  out  16  number of spam samples accepted (saturating).

Behaviour:
- Reset values: state=CLEAR, word_idx=0, in_ready=0, out_valid=0, out_data=0, out_class=0, out_last=0, err_frame=0, cnt_ham=0, cnt_spam=0, busy=1.
- The accumulator array is not reset directly. CLEAR sweeps one word (W counters per class) per cycle, taking NUM_WORDS cycles, then goes to IDLE.
- States: IDLE, CLEAR, ACCUM, READ.
- IDLE priority when several requests arrive together: clear, then rd_start, then in_valid. in_ready=1 in IDLE.
- In IDLE, an accepted word is word 0: latch in_label and accumulate. Next state is ACCUM, or stays IDLE if in_last with NUM_WORDS=1.
- ACCUM, per accepted word (in_valid & in_ready):
  - Each bit d of the selected class's counter at word_idx gets +1 if the bit is 1, -1 if 0.
  - Counters saturate at ±(2^(CNT_W-1)-1).
  - Bits at positions ≥ DIM in the final word are ignored.
  - in_ready stays 1 in ACCUM; one word per cycle, no bubbles.
- End of sample:
  - in_last with word_idx==NUM_WORDS-1: increment the labelled count (saturating at 0xFFFF), word_idx←0, go to IDLE.
  - in_last with word_idx≠NUM_WORDS-1: set err_frame, word_idx←0, go to IDLE, do not count the sample. Partial accumulation is kept.
  - word_idx==NUM_WORDS-1 without in_last: set err_frame, wrap word_idx to 0, stay in ACCUM, do not count the sample.
- rd_start is ignored outside IDLE.
- clear in ACCUM or READ aborts the operation and goes to CLEAR. Counts are zeroed; err_frame is kept. Only reset clears err_frame.
- READ:
  - out_valid rises 1 cycle after rd_start.
  - Streams class 0 words 0..NUM_WORDS-1, then class 1 words 0..NUM_WORDS-1.
  - out_data bit d = 1 iff counter > 0; a tie (counter 0) gives 0. Bits ≥ DIM read as 0.
  - out_last is high on word NUM_WORDS-1 of each class.
  - out_data, out_class and out_last are held stable while out_valid & !out_ready.
  - The next word follows the cycle after each handshake, so full throughput is 1 word/cycle.
  - After the final class-1 handshake, out_valid=0 and the state returns to IDLE.
- Readout does not modify the counters. Training may continue after a readout.

Decomposition:
- Package hdc_pkg holds:
  - DIM, W, NUM_WORDS;
  - CLASS_HAM=0, CLASS_SPAM=1;
  - the state enum;
  - the bipolar mapping constants (+1/-1).
  The classifier shares the same package.
- Sub-module hdc_sat_acc: one CNT_W-bit saturating ±1 accumulator with an enable. It is instantiated W times to form the per-cycle update lane, reading and writing one word slice of the counter array.

Test Plan (DIM=64, W=32, NUM_WORDS=2, CNT_W=16 unless stated):
- Reset release → busy=1 for 2 cycles (CLEAR), then IDLE with in_ready=1. rd_start → 4 words, all 0x00000000, out_last on the 2nd and 4th words.
- One ham sample {0xFFFF0000, 0x0000FFFF} → readout ham {0xFFFF0000, 0x0000FFFF}, spam {0, 0}; cnt_ham=1, cnt_spam=0.
- Three ham samples with word0 = 0xF0F0F0F0, 0xF0F0F0F0, 0x0F0F0F0F (word1 = 0) → ham word0 = 0xF0F0F0F0 (majority), word1 = 0; cnt_ham=3.
- CNT_W=4: 9 spam samples of all-ones, then 7 of all-zeros → counters 7-7=0 → spam words 0x00000000 (without saturation the sum is +2 and would read all-ones); cnt_spam=16.
- Framing errors, then clear:
  - in_last on word 0 → err_frame=1, cnt unchanged, in_ready=1 next cycle.
  - A 3-word sample without in_last on word 1 → err_frame stays 1.
  - A clear pulse then zeroes the counts but err_frame remains 1.
- Readout backpressure: hold out_ready=0 for 5 cycles on word 1 → out_data, out_class and out_last stable. clear during READ → out_valid=0 next cycle, 2 CLEAR cycles, then readout gives all zeros.
